// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 8-digit seven-segment scan back into a BCD frame.
// Each digit is captured once per dwell after it has been stable for SETTLE edges.
module seg_scan_decoder #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_com,
    input  logic [7:0]  seg_data,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  err,
    output logic        frame_valid,
    output logic        scan_lost
);

    localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    // Returns {err, nibble}; anything that is not a clean 0-9 glyph decodes to F with err set.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode_glyph = {1'b0, 4'd0};
            7'b0110000: decode_glyph = {1'b0, 4'd1};
            7'b1101101: decode_glyph = {1'b0, 4'd2};
            7'b1111001: decode_glyph = {1'b0, 4'd3};
            7'b0110011: decode_glyph = {1'b0, 4'd4};
            7'b1011011: decode_glyph = {1'b0, 4'd5};
            7'b1011111: decode_glyph = {1'b0, 4'd6};
            7'b1110000: decode_glyph = {1'b0, 4'd7};
            7'b1111111: decode_glyph = {1'b0, 4'd8};
            7'b1111011: decode_glyph = {1'b0, 4'd9};
            default:    decode_glyph = {1'b1, 4'hF};
        endcase
    endfunction

    function automatic logic one_low(input logic [7:0] com);
        logic [7:0] low;
        low     = ~com;
        one_low = (low != 8'h00) && ((low & (low - 8'd1)) == 8'h00);
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] com);
        low_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!com[i]) begin
                low_index = 3'(i);
            end
        end
    endfunction

    logic [7:0]  r_com;
    logic [7:0]  r_data;
    logic [3:0]  r_cnt;
    logic [15:0] r_idle;
    logic [7:0]  r_seen;
    logic [31:0] r_stg_dig;
    logic [7:0]  r_stg_dp;
    logic [7:0]  r_stg_err;
    logic [31:0] r_digits;
    logic [7:0]  r_dp;
    logic [7:0]  r_err;
    logic        r_frame_valid;
    logic        r_scan_lost;

    logic        w_valid;
    logic        w_same;
    logic [3:0]  w_cnt_next;
    logic        w_cap;
    logic [2:0]  w_idx;
    logic [4:0]  w_glyph;
    logic [7:0]  w_set;
    logic [15:0] w_idle_next;
    logic        w_timeout;

    // Stability tracking compares the pair being sampled now with the previously registered pair.
    always_comb begin
        w_valid     = one_low(r_com);
        w_same      = (seg_com == r_com) && (seg_data == r_data);
        w_cnt_next  = 4'd0;
        if (w_same && w_valid) begin
            if (r_cnt == SETTLE_C) begin
                w_cnt_next = r_cnt;
            end else begin
                w_cnt_next = r_cnt + 4'd1;
            end
        end else begin
            w_cnt_next = 4'd0;
        end
        w_cap       = (w_cnt_next == SETTLE_C) && (r_cnt != SETTLE_C);
        w_idx       = low_index(r_com);
        w_glyph     = decode_glyph(r_data[7:1]);
        w_set       = w_cap ? (8'd1 << w_idx) : 8'h00;
        if (w_cap) begin
            w_idle_next = 16'd0;
        end else if (r_idle == TIMEOUT_C) begin
            w_idle_next = r_idle;
        end else begin
            w_idle_next = r_idle + 16'd1;
        end
        w_timeout   = (w_idle_next == TIMEOUT_C);
    end

    // Input stage and stability/idle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_com  <= 8'hFF;
            r_data <= 8'h00;
            r_cnt  <= 4'd0;
            r_idle <= 16'd0;
        end else begin
            r_com  <= seg_com;
            r_data <= seg_data;
            r_cnt  <= w_cnt_next;
            r_idle <= w_idle_next;
        end
    end

    // Staging entries for the frame under construction; recapture simply overwrites.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg_dig <= 32'h0000_0000;
            r_stg_dp  <= 8'h00;
            r_stg_err <= 8'h00;
        end else if (w_cap) begin
            r_stg_dig[{w_idx, 2'b00} +: 4] <= w_glyph[3:0];
            r_stg_dp[w_idx]                <= r_data[0];
            r_stg_err[w_idx]               <= w_glyph[4];
        end else begin
            r_stg_dig <= r_stg_dig;
            r_stg_dp  <= r_stg_dp;
            r_stg_err <= r_stg_err;
        end
    end

    // Frame completion publishes staging one edge after coverage is full; a capture on that edge starts the next set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen        <= 8'h00;
            r_digits      <= 32'h0000_0000;
            r_dp          <= 8'h00;
            r_err         <= 8'h00;
            r_frame_valid <= 1'b0;
            r_scan_lost   <= 1'b0;
        end else begin
            r_scan_lost <= (r_idle == TIMEOUT_C);
            if (r_seen == 8'hFF) begin
                r_digits      <= r_stg_dig;
                r_dp          <= r_stg_dp;
                r_err         <= r_stg_err;
                r_frame_valid <= 1'b1;
                r_seen        <= w_set;
            end else begin
                r_frame_valid <= 1'b0;
                if (w_timeout) begin
                    r_seen <= 8'h00;
                end else begin
                    r_seen <= r_seen | w_set;
                end
            end
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign err         = r_err;
    assign frame_valid = r_frame_valid;
    assign scan_lost   = r_scan_lost;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 2, consecutive sampling edges a (seg_com, seg_data) pair must stay constant before capture; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 1024, cycles without a capture before scan_lost asserts; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 seg_com  input  8  digit select, active-low, bit i selects digit i.
REQ-006 seg_data  input  8  segments, active-high, bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-007 digits  output  32  decoded BCD frame; nibble [4i+3:4i] = digit i.
REQ-008 dp  output  8  decimal-point bit per digit, from the last completed frame.
REQ-009 err  output  8  bit i high = digit i pattern not a legal 0-9 glyph in the last completed frame.
REQ-010 frame_valid  output  1  one-cycle pulse when digits/dp/err update.
REQ-011 scan_lost  output  1  level, high while no capture for TIMEOUT cycles.

Function
REQ-012 seg_com and seg_data SHALL be registered once (input stage) before any use; all timing below counts edges at which this stage samples.
REQ-013 A pair SHALL be valid only if the registered seg_com has exactly one bit low; all other seg_com values (0xFF, multi-low) SHALL clear the stability counter and block capture.
REQ-014 Stability counter: +1 per edge when the registered pair equals the previous registered pair and is valid, saturating at SETTLE; otherwise reset to 0.
REQ-015 A pair first sampled at edge N and held constant SHALL be captured at edge N+SETTLE, exactly once per dwell; a longer hold SHALL NOT recapture.
REQ-016 Capture SHALL write staging nibble i, staging dp[i], staging err[i] and set seen[i], where i is the low bit of seg_com.
REQ-017 Decode of seg_data[7:1] (abcdefg): 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9; any other pattern SHALL yield nibble 4'hF and err=1; dp SHALL be seg_data[0] unchanged.
REQ-018 Recapturing a digit already in seen SHALL overwrite its staging entry without error.
REQ-019 When seen becomes 8'hFF at edge M, digits/dp/err SHALL load from staging at edge M+1 and frame_valid SHALL be high for exactly the cycle after edge M+1; seen SHALL clear at edge M+1.
REQ-020 A capture at edge M+1 (concurrent with frame completion) SHALL land in the new, cleared seen set.
REQ-021 Digit order of capture SHALL be irrelevant; only full coverage of all 8 digits completes a frame.
REQ-022 Idle counter SHALL clear on every capture and otherwise increment, saturating; on reaching TIMEOUT, scan_lost SHALL go high and seen SHALL clear; digits/dp/err SHALL hold.
REQ-023 scan_lost SHALL deassert on the edge after the next capture.
REQ-024 Between frames, digits/dp/err SHALL hold their last values.

Reset
REQ-025 While rst is high: digits=0, dp=0, err=0, frame_valid=0, scan_lost=0, seen=0, staging=0, counters=0, input registers=seg_com 8'hFF / seg_data 8'h00.
REQ-026 rst asserted mid-frame SHALL discard partial staging; the first frame after release requires all 8 digits recaptured.

Verification
REQ-027 SETTLE=2, scan digits 0..7 showing 1,2,3,4,5,6,7,8 (no dp), 4 cycles each -> one frame_valid pulse, digits=32'h87654321, dp=0, err=0.
REQ-028 Same scan, digit 3 seg_data=8'b0000_0001 -> digits nibble 3 = F, err=8'h08, dp=8'h08.
REQ-029 Digit held only SETTLE-1 = 1 stable cycle with changing seg_data -> no capture, no frame_valid after 8 such slots.
REQ-030 seg_com=8'hFF for TIMEOUT cycles after 5 captures -> scan_lost=1, seen cleared, next full 8-digit scan yields one frame_valid and scan_lost=0.
REQ-031 rst pulse after 4 captures, then full scan -> exactly one frame_valid, only post-reset values in digits.
REQ-032 Continuous scan of 3 frames, digit 0 held 20 cycles -> exactly 3 frame_valid pulses, one capture per dwell.
